// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, command field positions and power-on init ROM for the LCD scheduler
package lcd_pkg;
  typedef enum logic [3:0] {
    S_PWR_WAIT, S_INIT_LOAD, S_IDLE, S_SETUP, S_EHI1, S_GAP, S_EHI2, S_SETTLE, S_DONE
  } state_t;
  localparam int RS_BIT = 8;
  localparam int NIB_BIT = 9;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [9:0] INIT_ROM [8] = '{
    10'h230, 10'h230, 10'h230, 10'h220, 10'h028, 10'h00C, 10'h006, 10'h001
  };
endpackage

// File: rtl/lcd_init_rom.sv
// lcd_init_rom: combinational lookup of the power-on init sequence as {nib_only, rs, byte}
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0] addr,
  output logic [9:0] word
);
  assign word = INIT_ROM[addr];
endmodule

// File: rtl/lcd_cmd_scheduler.sv
// lcd_cmd_scheduler: runs LCD power-on init, then round-robin schedules two requesters onto the 4-bit bus
module lcd_cmd_scheduler
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 5,
  parameter int E_HIGH_CYC  = 15,
  parameter int NIBBLE_GAP  = 10,
  parameter int SHORT_DELAY = 2500,
  parameter int LONG_DELAY  = 110000,
  parameter int PWR_WAIT    = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [8:0] data0,
  input  logic [8:0] data1,
  output logic [1:0] ack,
  output logic       busy,
  output logic       init_done,
  output logic       rs,
  output logic       e,
  output logic [3:0] d
);
  localparam int MAXC = PWR_WAIT > LONG_DELAY ? PWR_WAIT : LONG_DELAY;
  localparam int CW = $clog2(MAXC);
  state_t state;
  logic [CW-1:0] cnt, lim;
  logic [2:0] idx;
  logic [9:0] cmd, rom_word;
  logic [8:0] sel;
  logic rr, gnt, pick, hit, lng;
  lcd_init_rom u_rom (.addr(idx), .word(rom_word));
  always_comb begin
    lng = !cmd[RS_BIT] && (cmd[7:0] == CMD_CLEAR || cmd[7:0] == CMD_HOME);
    lim = state == S_PWR_WAIT ? CW'(PWR_WAIT - 1) :
          state == S_SETUP ? CW'(SETUP_CYC - 1) :
          (state == S_EHI1 || state == S_EHI2) ? CW'(E_HIGH_CYC - 1) :
          state == S_GAP ? CW'(NIBBLE_GAP - 1) :
          state == S_SETTLE ? (lng ? CW'(LONG_DELAY - 1) : CW'(SHORT_DELAY - 1)) : '0;
    hit = cnt == lim;
    pick = req[rr] ? rr : ~rr;
    sel = pick ? data1 : data0;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_PWR_WAIT;
      cnt <= '0;
      idx <= '0;
      rr <= 1'b0;
      gnt <= 1'b0;
      cmd <= '0;
      rs <= 1'b0;
      e <= 1'b0;
      d <= '0;
      ack <= '0;
      init_done <= 1'b0;
      busy <= 1'b1;
    end else begin
      ack <= '0;
      cnt <= hit ? '0 : cnt + CW'(1);
      case (state)
        S_PWR_WAIT: if (hit) state <= S_INIT_LOAD;
        S_INIT_LOAD: begin
          cmd <= rom_word;
          rs <= rom_word[RS_BIT];
          d <= rom_word[7:4];
          state <= S_SETUP;
        end
        S_IDLE: if (init_done && req[pick]) begin
          gnt <= pick;
          cmd <= {1'b0, sel};
          rs <= sel[RS_BIT];
          d <= sel[7:4];
          busy <= 1'b1;
          state <= S_SETUP;
        end
        S_SETUP: if (hit) begin
          e <= 1'b1;
          state <= S_EHI1;
        end
        S_EHI1: if (hit) begin
          e <= 1'b0;
          state <= cmd[NIB_BIT] ? S_SETTLE : S_GAP;
        end
        S_GAP: begin
          // low nibble changes one cycle after e fell so it never moves on the e edge
          if (cnt == '0) d <= cmd[3:0];
          if (hit) begin
            e <= 1'b1;
            state <= S_EHI2;
          end
        end
        S_EHI2: if (hit) begin
          e <= 1'b0;
          state <= S_SETTLE;
        end
        S_SETTLE: if (hit) begin
          if (init_done) ack[gnt] <= 1'b1;
          state <= S_DONE;
        end
        S_DONE: if (init_done) begin
          rr <= ~gnt;
          busy <= 1'b0;
          state <= S_IDLE;
        end else begin
          idx <= idx + 3'd1;
          if (idx == 3'd7) begin
            init_done <= 1'b1;
            busy <= 1'b0;
            state <= S_IDLE;
          end else state <= S_INIT_LOAD;
        end
        default: state <= S_PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_cmd_scheduler.sv
// tb_lcd_cmd_scheduler: vector table, hand sequences and randomized requesters against a transaction-level model
module tb_lcd_cmd_scheduler;
  localparam int PW = 20, SU = 2, EH = 3, GP = 2, SH = 8, LG = 30;
  localparam int NX = SH + 2 + SU;
  typedef struct {logic rs; logic [3:0] d; int rise; int fall;} pulse_t;
  typedef struct {bit who; logic [8:0] dat; logic rs; logic [3:0] hi; logic [3:0] lo; int settle;} vec_t;
  logic clock = 0, reset = 0, r0 = 0, r1 = 0;
  logic [8:0] data0 = '0, data1 = '0;
  logic [1:0] req, ack;
  logic busy, init_done, rs, e;
  logic [3:0] d;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  pulse_t pq[$];
  vec_t vt [8];
  logic [3:0] init_d [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'hC, 4'h0, 4'h6, 4'h0, 4'h1};
  int init_gap [11] = '{NX, NX, NX, NX, GP, NX, GP, NX, GP, NX, GP};
  assign req = {r1, r0};
  lcd_cmd_scheduler #(.SETUP_CYC(SU), .E_HIGH_CYC(EH), .NIBBLE_GAP(GP), .SHORT_DELAY(SH),
    .LONG_DELAY(LG), .PWR_WAIT(PW)) dut (.clock(clock), .reset(reset), .req(req), .data0(data0),
    .data1(data1), .ack(ack), .busy(busy), .init_done(init_done), .rs(rs), .e(e), .d(d));
  always #5 clock = ~clock;
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int settle_of(input logic [8:0] x);
    return (!x[8] && (x[7:0] == 8'h01 || x[7:0] == 8'h02)) ? LG : SH;
  endfunction
  logic [1:0] req_hist [1024];
  logic [17:0] dat_hist [1024];
  always @(posedge clock) begin
    cyc = cyc + 1;
    req_hist[cyc % 1024] = req;
    dat_hist[cyc % 1024] = {data1, data0};
  end
  // bus monitor: decodes each e pulse and checks rs/d never move around a high e
  logic pe = 0, prs = 0, moved = 0;
  logic [3:0] pd = '0;
  int rise_c = 0;
  pulse_t pp;
  always @(negedge clock) begin
    if (!reset) moved = 0;
    else if ((e || pe) && {rs, d} != {prs, pd}) moved = 1;
    if (reset && e && !pe) rise_c = cyc;
    if (reset && !e && pe) begin
      chk("e_width", cyc - rise_c, EH);
      chk("bus_hold", moved, 0);
      moved = 0;
      pp.rs = prs; pp.d = pd; pp.rise = rise_c; pp.fall = cyc;
      pq.push_back(pp);
    end
    pe = e; prs = rs; pd = d;
  end
  // transaction model: grant rule, data capture at grant, total write time from phase lengths
  bit m_ready = 0, pv = 0, rr_m = 0, p_who = 0;
  int idle_from = 0, p_ack = 0;
  logic [8:0] p_dat;
  logic [1:0] mr;
  logic [17:0] md;
  always @(negedge clock) begin
    if (!reset) begin
      m_ready = 0; pv = 0; rr_m = 0;
    end else begin
      if (init_done && !m_ready) begin
        m_ready = 1; idle_from = cyc + 1;
      end
      mr = req_hist[cyc % 1024];
      md = dat_hist[cyc % 1024];
      if (m_ready && !pv && cyc >= idle_from && mr != 2'b00) begin
        p_who = mr[rr_m] ? rr_m : !rr_m;
        p_dat = p_who ? md[17:9] : md[8:0];
        p_ack = cyc + SU + 2 * EH + GP + settle_of(p_dat);
        pv = 1;
      end
      if (ack != 2'b00) begin
        chk("ack_expected", pv, 1);
        if (pv && pq.size() >= 2) begin
          chk("m_ack_who", ack, 2'b01 << p_who);
          chk("m_ack_time", cyc, p_ack);
          chk("m_rs", {pq[$-1].rs, pq[$].rs}, {2{p_dat[8]}});
          chk("m_nib", {pq[$-1].d, pq[$].d}, p_dat[7:0]);
          chk("m_settle", cyc - pq[$].fall, settle_of(p_dat));
          rr_m = !p_who;
        end
        pv = 0;
        idle_from = cyc + 2;
      end else if (pv && cyc > p_ack) begin
        chk("m_ack_missing", 0, 1);
        pv = 0;
        idle_from = cyc;
      end
    end
  end
  task automatic wait_cond(input int which, input string nm);
    int k;
    bit got;
    k = 0; got = 0;
    while (!got && k < 400) begin
      @(negedge clock);
      k++;
      got = which == 0 ? e : which == 1 ? !e : which == 2 ? ack[0] : ack[1];
    end
    if (!got) chk(nm, 0, 1);
  endtask
  task automatic write_one(input bit who, input logic [8:0] dat, output int ac);
    @(negedge clock);
    if (who) begin data1 = dat; r1 = 1; end else begin data0 = dat; r0 = 1; end
    wait_cond(who ? 3 : 2, "wr_ack_timeout");
    ac = cyc;
    if (who) r1 = 0; else r0 = 0;
  endtask
  task automatic check_init(input int rel, output int idc);
    int k;
    k = 0; idc = 0;
    while (!init_done && k < 3000) begin @(negedge clock); k++; end
    idc = cyc;
    chk("init_done_seen", init_done, 1);
    chk("init_pulses", pq.size(), 12);
    chk("init_busy", busy, 0);
    if (pq.size() == 12) begin
      chk("init_first_rise", pq[0].rise - rel, PW + 1 + SU);
      for (int i = 0; i < 12; i++) begin
        chk("init_d", pq[i].d, init_d[i]);
        chk("init_rs", pq[i].rs, 0);
      end
      for (int i = 0; i < 11; i++) chk("init_gap", pq[i + 1].rise - pq[i].fall, init_gap[i]);
      chk("init_settle", idc - pq[11].fall, LG + 1);
    end
  endtask
  task automatic requester(input bit who, input int cnt);
    logic [8:0] v;
    for (int k = 0; k < cnt; k++) begin
      repeat ($urandom_range(1, 12)) @(negedge clock);
      v = ($urandom_range(0, 3) == 0) ? {1'($urandom_range(0, 1)), 8'($urandom_range(1, 2))} : 9'($urandom);
      if (who) begin data1 = v; r1 = 1; end else begin data0 = v; r0 = 1; end
      wait_cond(who ? 3 : 2, "rand_ack_timeout");
      if (who) r1 = 0; else r0 = 0;
    end
  endtask
  initial begin
    int idc, n, a, k;
    int got [4];
    logic [7:0] nib [4];
    vt[0] = '{1'b0, 9'h148, 1'b1, 4'h4, 4'h8, SH};
    vt[1] = '{1'b0, 9'h001, 1'b0, 4'h0, 4'h1, LG};
    vt[2] = '{1'b0, 9'h101, 1'b1, 4'h0, 4'h1, SH};
    vt[3] = '{1'b1, 9'h002, 1'b0, 4'h0, 4'h2, LG};
    vt[4] = '{1'b1, 9'h102, 1'b1, 4'h0, 4'h2, SH};
    vt[5] = '{1'b0, 9'h080, 1'b0, 4'h8, 4'h0, SH};
    vt[6] = '{1'b1, 9'h1FF, 1'b1, 4'hF, 4'hF, SH};
    vt[7] = '{1'b1, 9'h003, 1'b0, 4'h0, 4'h3, SH};
    repeat (3) @(negedge clock);
    chk("rst_rs", rs, 0);
    chk("rst_e", e, 0);
    chk("rst_d", d, 0);
    chk("rst_ack", ack, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_busy", busy, 1);
    reset = 1;
    check_init(cyc, idc);
    for (int i = 0; i < 8; i++) begin
      n = pq.size();
      write_one(vt[i].who, vt[i].dat, a);
      chk("vec_pulses", pq.size() - n, 2);
      if (pq.size() >= 2) begin
        chk("vec_rs", {pq[$-1].rs, pq[$].rs}, {2{vt[i].rs}});
        chk("vec_hi", pq[$-1].d, vt[i].hi);
        chk("vec_lo", pq[$].d, vt[i].lo);
        chk("vec_settle", a - pq[$].fall, vt[i].settle);
      end
    end
    @(negedge clock);
    data0 = 9'h141; data1 = 9'h152; r0 = 1; r1 = 1;
    k = 0; n = 0;
    for (int i = 0; i < 4; i++) begin got[i] = 0; nib[i] = '0; end
    while (n < 4 && k < 600) begin
      @(negedge clock);
      k++;
      if (ack != 2'b00) begin
        got[n] = int'(ack);
        nib[n] = {pq[$-1].d, pq[$].d};
        n++;
      end
    end
    r0 = 0; r1 = 0;
    chk("alt_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      chk("alt_ack", got[i], (i % 2) ? 2 : 1);
      chk("alt_data", nib[i], (i % 2) ? 8'h52 : 8'h41);
    end
    @(negedge clock);
    data0 = 9'h148; r0 = 1;
    wait_cond(0, "latch_e_timeout");
    data0 = 9'h0FF;
    wait_cond(2, "latch_ack_timeout");
    r0 = 0;
    chk("latch_rs", {pq[$-1].rs, pq[$].rs}, 2'b11);
    chk("latch_nib", {pq[$-1].d, pq[$].d}, 8'h48);
    @(negedge clock);
    data0 = 9'h001; r0 = 1;
    wait_cond(0, "drop_e_timeout");
    data1 = 9'h155; r1 = 1;
    repeat (5) @(negedge clock);
    r1 = 0;
    wait_cond(2, "drop_ack_timeout");
    r0 = 0;
    n = pq.size(); a = 0;
    repeat (60) begin @(negedge clock); if (ack[1]) a++; end
    chk("drop_no_write", pq.size() - n, 0);
    chk("drop_no_ack", a, 0);
    data0 = 9'h148; r0 = 1;
    wait_cond(0, "rst_ehi1_timeout");
    wait_cond(1, "rst_gap_timeout");
    wait_cond(0, "rst_ehi2_timeout");
    reset = 0;
    @(negedge clock);
    r0 = 0;
    chk("mid_rst_e", e, 0);
    chk("mid_rst_d", d, 0);
    chk("mid_rst_rs", rs, 0);
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_init_done", init_done, 0);
    chk("mid_rst_busy", busy, 1);
    repeat (2) @(negedge clock);
    pq.delete();
    reset = 1; data1 = 9'h153; r1 = 1;
    check_init(cyc, idc);
    wait_cond(3, "early_ack_timeout");
    r1 = 0;
    chk("early_pulses", pq.size(), 14);
    chk("early_rise", pq.size() > 12 ? pq[12].rise - idc : -1, SU + 1);
    fork
      requester(1'b0, 12);
      requester(1'b1, 12);
    join
    repeat (50) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
